// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
//   Execute-stage ALU. Takes the 4-bit operation code from the ALU controller,
//   both operands and a destination tag. It returns a registered result, a zero
//   flag and the tag. Logic and arithmetic ops finish on the accept edge.
//   Shifts of two or more positions run on a serial shifter that moves one bit
//   per cycle. The unit stays busy until the last step is done.
//
// Ports
//   clk          rising-edge clock
//   reset_n      synchronous active-low reset
//   in_valid     operation presented by upstream
//   in_ready     unit accepts this cycle (combinational)
//   in_op        operation code
//   in_a, in_b   rs1 operand, rs2 operand or immediate (shamt = in_b[SHAMT_W-1:0])
//   in_rd        destination tag, passed through unchanged
//   out_valid    result register holds a valid result
//   out_ready    downstream consumes this cycle
//   out_result   registered result
//   out_zero     registered (out_result == 0)
//   out_rd       registered tag
//   busy         serial shift in progress
// -----------------------------------------------------------------------------
module alu_exec_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int SHAMT_W    = 5
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            in_op,
   input  logic [DATA_WIDTH-1:0] in_a,
   input  logic [DATA_WIDTH-1:0] in_b,
   input  logic [4:0]            in_rd,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_result,
   output logic                  out_zero,
   output logic [4:0]            out_rd,
   output logic                  busy
);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_SLL  = 4'b0101;
   localparam logic [3:0] OP_SRL  = 4'b0110;
   localparam logic [3:0] OP_SRA  = 4'b0111;
   localparam logic [3:0] OP_EQ   = 4'b1000;
   localparam logic [3:0] OP_SLT  = 4'b1001;
   localparam logic [3:0] OP_SLTU = 4'b1010;

   localparam logic [SHAMT_W-1:0] CNT_ONE = 1;

   // The low two op bits are enough to name the shift kind:
   // 01 = SLL, 10 = SRL, 11 = SRA.
   localparam logic [1:0] K_SLL = 2'b01;
   localparam logic [1:0] K_SRL = 2'b10;
   localparam logic [1:0] K_SRA = 2'b11;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_e;

   // Context of a serial shift in flight.
   typedef struct packed {
      logic [DATA_WIDTH-1:0] val;
      logic [1:0]            kind;
      logic [4:0]            rd;
      logic [SHAMT_W-1:0]    cnt;
   } shift_ctx_t;

   state_e     state_q, state_d;
   shift_ctx_t sh_q, sh_d;

   logic                  accept;
   logic                  is_shift;
   logic                  long_shift;
   logic                  last_step;
   logic [SHAMT_W-1:0]    shamt;
   logic [DATA_WIDTH-1:0] first_step;
   logic [DATA_WIDTH-1:0] single_res;
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] wr_res;
   logic [4:0]            wr_rd;

   // One-position shift. SRA feeds the current MSB back in. The MSB never
   // changes during an arithmetic shift, so this always copies in_a's sign.
   function automatic logic [DATA_WIDTH-1:0] shift1(input logic [1:0]            kind,
                                                    input logic [DATA_WIDTH-1:0] x);
      logic [DATA_WIDTH-1:0] r;
      case (kind)
         K_SLL:   r = x << 1;
         K_SRL:   r = x >> 1;
         K_SRA:   r = {x[DATA_WIDTH-1], x[DATA_WIDTH-1:1]};
         default: r = x;
      endcase
      return r;
   endfunction

   // ---------------------------------------------------------------- handshake
   assign in_ready = (state_q == S_IDLE) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign busy     = (state_q == S_SHIFT);

   assign shamt      = in_b[SHAMT_W-1:0];
   assign is_shift   = (in_op == OP_SLL) || (in_op == OP_SRL) || (in_op == OP_SRA);
   assign long_shift = is_shift && (shamt > CNT_ONE);
   assign first_step = shift1(in_op[1:0], in_a);

   // ------------------------------------------------------- single-cycle result
   // Shifts of 0 or 1 position finish here. Longer shifts take first_step
   // into the serial shifter instead.
   always_comb begin
      single_res = '0;
      case (in_op)
         OP_AND:  single_res = in_a & in_b;
         OP_SUB:  single_res = in_a - in_b;
         OP_ADD:  single_res = in_a + in_b;
         OP_OR:   single_res = in_a | in_b;
         OP_XOR:  single_res = in_a ^ in_b;
         OP_SLL,
         OP_SRL,
         OP_SRA:  single_res = (shamt == '0) ? in_a : first_step;
         OP_EQ:   single_res = DATA_WIDTH'(in_a == in_b);
         OP_SLT:  single_res = DATA_WIDTH'($signed(in_a) < $signed(in_b));
         OP_SLTU: single_res = DATA_WIDTH'(in_a < in_b);
         default: single_res = '0;
      endcase
   end

   // ------------------------------------------------------------------ FSM
   // The count is loaded with the full shift amount, and the first shift is
   // done on the accept edge. Each SHIFT cycle shifts once more and counts
   // down. The step that leaves the count at 1 is the last one, so a shift
   // of N positions spends N-1 cycles in SHIFT.
   always_comb begin
      state_d   = state_q;
      sh_d      = sh_q;
      last_step = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept && long_shift) begin
               state_d   = S_SHIFT;
               sh_d.val  = first_step;
               sh_d.kind = in_op[1:0];
               sh_d.rd   = in_rd;
               sh_d.cnt  = shamt;
            end
         end
         S_SHIFT: begin
            sh_d.val = shift1(sh_q.kind, sh_q.val);
            sh_d.cnt = sh_q.cnt - CNT_ONE;
            if (sh_d.cnt == CNT_ONE) begin
               last_step = 1'b1;
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         sh_q    <= '0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
      end
   end

   // -------------------------------------------------------- output register
   // Entry to SHIFT needed the output register to be free or draining. That
   // means the last shift step never has to wait for downstream.
   assign wr_en  = (accept && !long_shift) || last_step;
   assign wr_res = (state_q == S_SHIFT) ? sh_d.val : single_res;
   assign wr_rd  = (state_q == S_SHIFT) ? sh_q.rd  : in_rd;

   // A write on the same edge as a consume takes precedence, so out_valid
   // stays high across back-to-back results.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         out_valid  <= 1'b0;
         out_result <= '0;
         out_zero   <= 1'b1;
         out_rd     <= '0;
      end else if (wr_en) begin
         out_valid  <= 1'b1;
         out_result <= wr_res;
         out_zero   <= (wr_res == '0);
         out_rd     <= wr_rd;
      end else if (out_ready) begin
         out_valid  <= 1'b0;
      end
   end

endmodule
